// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: word-addressed data memory with a fixed number of wait
// states; stalls upstream via freeze and reports bad addresses on completion.
module mem_stage_ws #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_r_en_in,
  input  logic              MEM_w_en_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm,
  output logic              WB_en_out,
  output logic              MEM_r_en_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              freeze,
  output logic              addr_err
);

  localparam int BOFF  = $clog2(DATA_W / 8);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);
  localparam logic [DATA_W-1:0] BMASK    = DATA_W'((1 << BOFF) - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req, is_load, is_store, bad, complete, mem_we;
  logic [DATA_W-1:0] off, idx_full;
  logic [AW-1:0]     idx;

  always_comb begin
    req      = MEM_r_en_in | MEM_w_en_in;
    is_store = MEM_w_en_in;
    is_load  = MEM_r_en_in & ~MEM_w_en_in;
    off      = alu_res_in - BASE;
    idx_full = off >> BOFF;
    idx      = idx_full[AW-1:0];
    bad      = (alu_res_in < BASE) | (idx_full >= DEPTH_W) | ((off & BMASK) != '0);
  end

  // Reset also masks freeze combinationally so an aborted access releases the pipe at once.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    freeze   = 1'b0;
    if (!rst && req) begin
      if (WAIT_CYCLES == 0) begin
        complete = 1'b1;
      end else if (state_q == IDLE) begin
        freeze  = 1'b1;
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end else if (cnt_q != '0) begin
        freeze = 1'b1;
        cnt_d  = cnt_q - 1'b1;
      end else begin
        complete = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    dest_out     = dest_in;
    alu_res_out  = alu_res_in;
    WB_en_out    = freeze ? 1'b0 : WB_en_in;
    MEM_r_en_out = freeze ? 1'b0 : is_load;
    data_mem_out = '0;
    addr_err     = complete & bad;
    mem_we       = complete & is_store & ~bad;
    if (complete && is_load && !bad) begin
      data_mem_out = mem_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= val_rm;
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench for mem_stage_ws: default instance (3 wait states) and a
// zero-wait, 16-word instance, each with its own expectation queue and monitor.
module tb_mem_stage_ws;

  typedef struct {
    logic        wb;
    logic        rd;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
    logic        err;
    int          frz;
  } exp_t;

  logic clk, rst;

  logic        wb_i, rd_i, wr_i;
  logic [3:0]  dest_i;
  logic [31:0] alu_i, val_i;
  logic        wb_o, rd_o, freeze, addr_err;
  logic [3:0]  dest_o;
  logic [31:0] alu_o, data_o;

  logic        wb0_i, rd0_i, wr0_i;
  logic [3:0]  dest0_i;
  logic [31:0] alu0_i, val0_i;
  logic        wb0_o, rd0_o, freeze0, addr_err0;
  logic [3:0]  dest0_o;
  logic [31:0] alu0_o, data0_o;

  int n_total = 0;
  int n_bad   = 0;
  exp_t q[$];
  exp_t q0[$];
  int   run = 0;
  exp_t e, e0;

  mem_stage_ws dut (
    .clk(clk), .rst(rst),
    .WB_en_in(wb_i), .MEM_r_en_in(rd_i), .MEM_w_en_in(wr_i),
    .dest_in(dest_i), .alu_res_in(alu_i), .val_rm(val_i),
    .WB_en_out(wb_o), .MEM_r_en_out(rd_o), .dest_out(dest_o),
    .alu_res_out(alu_o), .data_mem_out(data_o),
    .freeze(freeze), .addr_err(addr_err)
  );

  mem_stage_ws #(.WAIT_CYCLES(0), .DEPTH(16)) dut0 (
    .clk(clk), .rst(rst),
    .WB_en_in(wb0_i), .MEM_r_en_in(rd0_i), .MEM_w_en_in(wr0_i),
    .dest_in(dest0_i), .alu_res_in(alu0_i), .val_rm(val0_i),
    .WB_en_out(wb0_o), .MEM_r_en_out(rd0_o), .dest_out(dest0_o),
    .alu_res_out(alu0_o), .data_mem_out(data0_o),
    .freeze(freeze0), .addr_err(addr_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Default instance monitor: freeze cycles must be bubbles; a non-frozen active cycle is a result.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else if (freeze) begin
      run++;
      chk("frz_wb", {31'b0, wb_o}, 32'd0);
      chk("frz_rd", {31'b0, rd_o}, 32'd0);
    end else begin
      if (wb_i | rd_i | wr_i) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("wb",     {31'b0, wb_o},     {31'b0, e.wb});
          chk("rd",     {31'b0, rd_o},     {31'b0, e.rd});
          chk("dest",   {28'b0, dest_o},   {28'b0, e.dest});
          chk("alu",    alu_o,             e.alu);
          chk("data",   data_o,            e.data);
          chk("err",    {31'b0, addr_err}, {31'b0, e.err});
          chk("frz_len", run,              e.frz);
        end
      end
      run = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && (wb0_i | rd0_i | wr0_i)) begin
      chk("w0_frz", {31'b0, freeze0}, 32'd0);
      if (q0.size() == 0) begin
        chk("sb0_unexpected", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("w0_wb",   {31'b0, wb0_o},     {31'b0, e0.wb});
        chk("w0_rd",   {31'b0, rd0_o},     {31'b0, e0.rd});
        chk("w0_data", data0_o,            e0.data);
        chk("w0_err",  {31'b0, addr_err0}, {31'b0, e0.err});
      end
    end
  end

  task automatic idle();
    wb_i = 0; rd_i = 0; wr_i = 0; dest_i = 0; alu_i = 0; val_i = 0;
  endtask

  task automatic op(input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
                    input logic [31:0] alu, input logic [31:0] val,
                    input logic [31:0] exp_data, input logic exp_err);
    exp_t x;
    wb_i = wb; rd_i = rd; wr_i = wr; dest_i = dest; alu_i = alu; val_i = val;
    x.wb = wb; x.rd = rd & ~wr; x.dest = dest; x.alu = alu;
    x.data = exp_data; x.err = exp_err; x.frz = (rd | wr) ? 3 : 0;
    q.push_back(x);
    repeat (x.frz + 1) @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic wb, input logic rd, input logic wr,
                     input logic [31:0] alu, input logic [31:0] val,
                     input logic [31:0] exp_data, input logic exp_err);
    exp_t x;
    wb0_i = wb; rd0_i = rd; wr0_i = wr; dest0_i = 4'd2; alu0_i = alu; val0_i = val;
    x.wb = wb; x.rd = rd & ~wr; x.dest = 4'd2; x.alu = alu;
    x.data = exp_data; x.err = exp_err; x.frz = 0;
    q0.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wb0_i = 0; rd0_i = 0; wr0_i = 0; dest0_i = 0; alu0_i = 0; val0_i = 0;
    #3;
    chk("rst_freeze", {31'b0, freeze},   32'd0);
    chk("rst_err",    {31'b0, addr_err}, 32'd0);
    chk("rst_data",   data_o,            32'd0);
    chk("rst_wb",     {31'b0, wb_o},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    op(1, 0, 0, 4'd5, 32'h1234, 0, 32'h0, 0);
    op(0, 0, 1, 4'd0, 32'd1028, 32'hDEADBEEF, 32'h0, 0);
    op(1, 1, 0, 4'd3, 32'd1028, 0, 32'hDEADBEEF, 0);
    op(0, 0, 1, 4'd0, 32'd1280, 32'h11, 32'h0, 1);
    op(1, 1, 0, 4'd3, 32'd1030, 0, 32'h0, 1);
    op(1, 1, 0, 4'd3, 32'd1028, 0, 32'hDEADBEEF, 0);
    op(1, 1, 0, 4'd3, 32'd1020, 0, 32'h0, 1);
    op(1, 1, 0, 4'd4, 32'd1276, 0, 32'h0, 0);
    op(1, 0, 0, 4'd6, 32'hABCD, 0, 32'h0, 0);

    // store aborted by reset in its second busy cycle
    wb_i = 0; rd_i = 0; wr_i = 1; dest_i = 0; alu_i = 32'd1032; val_i = 32'hCAFE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_freeze", {31'b0, freeze},   32'd0);
    chk("rst_mid_err",    {31'b0, addr_err}, 32'd0);
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    op(1, 1, 0, 4'd3, 32'd1032, 0, 32'h0, 0);
    op(1, 1, 0, 4'd3, 32'd1028, 0, 32'h0, 0);
    op(0, 0, 1, 4'd0, 32'd1032, 32'h55, 32'h0, 0);
    op(1, 1, 0, 4'd3, 32'd1032, 0, 32'h55, 0);
    op(1, 1, 1, 4'd7, 32'd1036, 32'h77, 32'h0, 0);
    op(1, 1, 0, 4'd7, 32'd1036, 0, 32'h77, 0);

    // store abandoned by dropping the request mid-access
    wb_i = 0; rd_i = 0; wr_i = 1; dest_i = 0; alu_i = 32'd1040; val_i = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    idle();
    @(posedge clk); #1;
    op(1, 1, 0, 4'd8, 32'd1040, 0, 32'h0, 0);
    idle();
    @(posedge clk); #1;

    op0(0, 0, 1, 32'd1084, 32'hA5, 32'h0, 0);
    op0(1, 1, 0, 32'd1084, 0, 32'hA5, 0);
    op0(1, 1, 0, 32'd1088, 0, 32'h0, 1);
    op0(0, 0, 1, 32'd1088, 32'hBB, 32'h0, 1);
    op0(1, 1, 0, 32'd1024, 0, 32'h0, 0);
    op0(1, 1, 0, 32'd1084, 0, 32'hA5, 0);
    wb0_i = 0; rd0_i = 0; wr0_i = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain", q.size() + q0.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
